inst_fifo: RTL and testbench
============================

INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, number of entries; power of two, at least 4.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: inst_in  input  32 x [2:0]  fetched instruction words, slot 0 oldest.
REQ-005 Port: pc_in  input  32 x [2:0]  PC of each fetch slot.
REQ-006 Port: valid_in  input  [2:0]  per-slot write-valid from the pre-decode stage.
REQ-007 Port: full  output  1  stall to fetch; writes this cycle are dropped when high.
REQ-008 Port: inst_out  output  32 x [2:0]  three oldest entries, slot 0 oldest.
REQ-009 Port: pc_out  output  32 x [2:0]  PCs matching inst_out.
REQ-010 Port: valid_out  output  [2:0]  valid_out[i] = (count > i).
REQ-011 Port: ready_dec  input  1  decoder consumes all asserted valid_out slots this cycle.
REQ-012 Port: flush  input  1  backend redirect; discards all contents.
REQ-013 Port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH entries {inst, pc}, with head (read) and tail (write) pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-015 full SHALL be combinational: full = (count > DEPTH-3), computed from registered count only; a same-cycle read does not clear it.
REQ-016 Write enable SHALL be !full && !flush; wcnt = popcount(valid_in) when enabled, else 0.
REQ-017 Valid slots SHALL be written in slot order, compacted and skipping invalid slots: pattern 3'b101 writes slot 0 at tail and slot 2 at tail+1.
REQ-018 Read SHALL be first-word-fall-through: inst_out[i]/pc_out[i] = entry[head+i mod DEPTH]; these outputs are don't-care when valid_out[i]=0.
REQ-019 rcnt SHALL be min(count,3) when ready_dec && !flush, else 0; partial consumption is not supported.
REQ-020 Per cycle: head += rcnt, tail += wcnt, count += wcnt - rcnt; simultaneous read and write SHALL both take effect.
REQ-021 Written data SHALL be visible on outputs no earlier than the next cycle; there is no write-to-read bypass.
REQ-022 flush SHALL take priority over everything: next cycle head=tail=0, count=0, and same-cycle writes and reads are discarded.
REQ-023 Entry storage SHALL NOT require reset; only pointers and count are reset.
REQ-024 count SHALL never exceed DEPTH or go below 0 under any legal input, including writes while at DEPTH-3.

Reset
REQ-025 While rst_n=0, immediately and asynchronously: head=0, tail=0, count=0, valid_out=3'b000, full=0.
REQ-026 Reset asserted mid-operation SHALL discard all contents; the first cycle after deassertion behaves as an empty FIFO.

Verification
REQ-027 Reset then idle -> count=0, valid_out=000, full=0 on every cycle.
REQ-028 valid_in=111, pc_in={0x1c008008,0x1c008004,0x1c008000}, ready_dec=0 -> next cycle count=3, valid_out=111, pc_out[0]=0x1c008000, pc_out[2]=0x1c008008.
REQ-029 valid_in=101 into empty FIFO -> next cycle count=2, valid_out=011, pc_out[1] = slot-2 PC.
REQ-030 Fill to count=14 (DEPTH=16) -> full=1 and a write of 111 is dropped; with ready_dec=1, count 14->11 and full drops next cycle.
REQ-031 Stream 3 writes and 3 reads per cycle for 20 cycles -> pointers wrap past 15, PC order preserved, count constant.
REQ-032 flush together with valid_in=111 and ready_dec=1 at count=5 -> next cycle count=0, valid_out=000, and the following write lands at entry 0.

Source files
------------

// File: rtl/inst_fifo.sv
// inst_fifo: three-wide instruction queue between fetch/pre-decode and decode.
//   Stores {inst, pc} in a DEPTH-entry circular buffer. Up to three valid
//   fetch slots are written per cycle, compacted in slot order, and the three
//   oldest entries are presented first-word-fall-through to the decoder.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   inst_in, pc_in        fetch slots (slot 0 oldest)
//   valid_in              per-slot write valid
//   full                  stall to fetch; writes are dropped while high
//   inst_out, pc_out      three oldest entries (slot 0 oldest)
//   valid_out             valid_out[i] = (count > i)
//   ready_dec             decoder takes every asserted valid_out slot
//   flush                 discard all contents (highest priority)
//   count                 current occupancy

// Per-lane address/valid generation for one of the three read/write slots.
module inst_fifo_lane #(
  parameter int AW   = 4,
  parameter int LANE = 0
) (
  input  logic [AW-1:0] head_i,
  input  logic [AW-1:0] tail_i,
  input  logic [AW:0]   count_i,
  input  logic [2:0]    valid_in_i,
  input  logic          wen_i,
  output logic [AW-1:0] raddr_o,
  output logic          rvalid_o,
  output logic [AW-1:0] waddr_o,
  output logic          we_o
);
  logic [AW-1:0] off;

  // Write offset is the number of valid slots older than this one, so
  // invalid slots are skipped and the written entries stay contiguous.
  always_comb begin
    off = '0;
    for (int j = 0; j < LANE; j++) off = off + AW'(valid_in_i[j]);
  end

  assign waddr_o  = tail_i + off;
  assign we_o     = wen_i & valid_in_i[LANE];
  assign raddr_o  = head_i + AW'(LANE);
  assign rvalid_o = count_i > (AW+1)'(LANE);
endmodule

module inst_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0][31:0]         inst_in,
  input  logic [2:0][31:0]         pc_in,
  input  logic [2:0]               valid_in,
  output logic                     full,
  output logic [2:0][31:0]         inst_out,
  output logic [2:0][31:0]         pc_out,
  output logic [2:0]               valid_out,
  input  logic                     ready_dec,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int NUM_LANES = 3;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  // Storage carries no reset; only pointers and occupancy do.
  entry_t mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                          wen;
  logic [1:0]                    wcnt, rcnt;
  logic [NUM_LANES-1:0][AW-1:0]  raddr, waddr;
  logic [NUM_LANES-1:0]          we, rvalid;

  // Full reserves three free slots so a whole fetch group always fits; it
  // looks only at the registered count, so a same-cycle read cannot clear it.
  assign full = count_q > CW'(DEPTH - 3);
  assign wen  = !full && !flush;

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      inst_fifo_lane #(.AW(AW), .LANE(l)) u_lane (
        .head_i     (head_q),
        .tail_i     (tail_q),
        .count_i    (count_q),
        .valid_in_i (valid_in),
        .wen_i      (wen),
        .raddr_o    (raddr[l]),
        .rvalid_o   (rvalid[l]),
        .waddr_o    (waddr[l]),
        .we_o       (we[l])
      );
      assign inst_out[l] = mem_q[raddr[l]].inst;
      assign pc_out[l]   = mem_q[raddr[l]].pc;
    end
  endgenerate

  assign valid_out = rvalid;
  assign count     = count_q;

  always_comb begin
    wcnt = 2'd0;
    for (int i = 0; i < NUM_LANES; i++) wcnt = wcnt + 2'(we[i]);
    rcnt = 2'd0;
    if (ready_dec && !flush)
      rcnt = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
  end

  always_comb begin
    head_d  = head_q + AW'(rcnt);
    tail_d  = tail_q + AW'(wcnt);
    count_d = count_q + CW'(wcnt) - CW'(rcnt);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Lanes with we set always target distinct entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (we[i]) mem_q[waddr[i]] <= '{inst: inst_in[i], pc: pc_in[i]};
  end
endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;
  logic             clk, rst_n;
  logic [2:0][31:0] inst_in, pc_in, inst_out, pc_out;
  logic [2:0]       valid_in, valid_out;
  logic             full, ready_dec, flush;
  logic [4:0]       count;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .pc_in(pc_in),
    .valid_in(valid_in), .full(full), .inst_out(inst_out), .pc_out(pc_out),
    .valid_out(valid_out), .ready_dec(ready_dec), .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  vin;
    logic        rd;
    logic        fl;
    logic [31:0] base;
    logic [4:0]  ecnt;
    logic [2:0]  evo;
    logic        efull;
    logic [2:0]  npc;   // which pc_out slots to check
    logic [31:0] epc0, epc1, epc2;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Slot i carries pc = base + 4*i and inst = ~pc.
  task automatic step(input logic [2:0] vin, input logic [31:0] base,
                      input logic rd, input logic fl);
    @(negedge clk);
    valid_in  = vin;
    ready_dec = rd;
    flush     = fl;
    for (int i = 0; i < 3; i++) begin
      pc_in[i]   = base + 32'(4 * i);
      inst_in[i] = ~(base + 32'(4 * i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [4:0] c, input logic [2:0] vo,
                           input logic f);
    chk({nm, ".count"}, 32'(count), 32'(c));
    chk({nm, ".valid_out"}, 32'(valid_out), 32'(vo));
    chk({nm, ".full"}, 32'(full), 32'(f));
  endtask

  logic [31:0] spc;
  int rd_idx;
  logic [31:0] m0;

  initial begin
    valid_in = '0; ready_dec = 0; flush = 0; pc_in = '0; inst_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_state("reset_async", 5'd0, 3'b000, 1'b0);

    // {vin, rd, fl, base, count, valid_out, full, pc mask, pc0, pc1, pc2}
    vt[0]  = '{3'b000, 0, 0, 32'h0,        0, 3'b000, 0, 3'b000, 0, 0, 0};
    vt[1]  = '{3'b111, 0, 0, 32'h1c008000, 3, 3'b111, 0, 3'b111, 32'h1c008000, 32'h1c008004, 32'h1c008008};
    vt[2]  = '{3'b000, 1, 0, 32'h0,        0, 3'b000, 0, 3'b000, 0, 0, 0};
    vt[3]  = '{3'b101, 0, 0, 32'h1000,     2, 3'b011, 0, 3'b011, 32'h1000, 32'h1008, 0};
    vt[4]  = '{3'b111, 0, 0, 32'h2000,     5, 3'b111, 0, 3'b111, 32'h1000, 32'h1008, 32'h2000};
    vt[5]  = '{3'b111, 1, 0, 32'h3000,     5, 3'b111, 0, 3'b111, 32'h2004, 32'h2008, 32'h3000};
    vt[6]  = '{3'b111, 0, 0, 32'h4000,     8, 3'b111, 0, 3'b001, 32'h2004, 0, 0};
    vt[7]  = '{3'b111, 0, 0, 32'h5000,    11, 3'b111, 0, 3'b001, 32'h2004, 0, 0};
    vt[8]  = '{3'b011, 0, 0, 32'h6000,    13, 3'b111, 0, 3'b001, 32'h2004, 0, 0};
    vt[9]  = '{3'b001, 0, 0, 32'h7000,    14, 3'b111, 1, 3'b001, 32'h2004, 0, 0};
    vt[10] = '{3'b111, 0, 0, 32'h8000,    14, 3'b111, 1, 3'b001, 32'h2004, 0, 0};
    vt[11] = '{3'b111, 1, 0, 32'h9000,    11, 3'b111, 0, 3'b111, 32'h3004, 32'h3008, 32'h4000};
    vt[12] = '{3'b111, 0, 0, 32'hA000,    14, 3'b111, 1, 3'b001, 32'h3004, 0, 0};
    vt[13] = '{3'b111, 1, 1, 32'hB000,     0, 3'b000, 0, 3'b000, 0, 0, 0};
    vt[14] = '{3'b111, 0, 0, 32'hC000,     3, 3'b111, 0, 3'b111, 32'hC000, 32'hC004, 32'hC008};
    vt[15] = '{3'b010, 1, 0, 32'hD000,     1, 3'b001, 0, 3'b001, 32'hD004, 0, 0};
    vt[16] = '{3'b000, 1, 0, 32'h0,        0, 3'b000, 0, 3'b000, 0, 0, 0};

    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset stays empty.
    for (int k = 0; k < 4; k++) begin
      step(3'b000, 32'h0, 1'b0, 1'b0);
      chk_state($sformatf("idle%0d", k), 5'd0, 3'b000, 1'b0);
    end

    for (int k = 0; k < 17; k++) begin
      step(vt[k].vin, vt[k].base, vt[k].rd, vt[k].fl);
      chk_state($sformatf("vec%0d", k), vt[k].ecnt, vt[k].evo, vt[k].efull);
      if (vt[k].npc[0]) begin
        chk($sformatf("vec%0d.pc0", k), pc_out[0], vt[k].epc0);
        chk($sformatf("vec%0d.inst0", k), inst_out[0], ~vt[k].epc0);
      end
      if (vt[k].npc[1]) chk($sformatf("vec%0d.pc1", k), pc_out[1], vt[k].epc1);
      if (vt[k].npc[2]) chk($sformatf("vec%0d.pc2", k), pc_out[2], vt[k].epc2);
    end

    // Streaming: 3 in / 3 out per cycle, pointers wrap several times.
    spc = 32'h1c010000;
    step(3'b111, spc, 1'b0, 1'b0);
    step(3'b111, spc + 32'd12, 1'b0, 1'b0);
    chk("stream_fill.count", 32'(count), 32'd6);
    rd_idx = 0;
    for (int c = 1; c <= 20; c++) begin
      step(3'b111, spc + 32'(12 * (c + 1)), 1'b1, 1'b0);
      rd_idx += 3;
      chk($sformatf("stream%0d.count", c), 32'(count), 32'd6);
      for (int s = 0; s < 3; s++)
        chk($sformatf("stream%0d.pc%0d", c, s), pc_out[s], spc + 32'(4 * (rd_idx + s)));
    end

    // Flush at count=5 with simultaneous write and read.
    step(3'b000, 32'h0, 1'b1, 1'b0);
    chk("pre_flush.count", 32'(count), 32'd3);
    step(3'b011, 32'h5500, 1'b0, 1'b0);
    chk("pre_flush2.count", 32'(count), 32'd5);
    step(3'b111, 32'h6600, 1'b1, 1'b1);
    chk_state("flush", 5'd0, 3'b000, 1'b0);
    step(3'b001, 32'hE000, 1'b0, 1'b0);
    chk_state("post_flush", 5'd1, 3'b001, 1'b0);
    chk("post_flush.pc0", pc_out[0], 32'hE000);
    m0 = dut.mem_q[0].pc;
    chk("post_flush.entry0", m0, 32'hE000);

    // Reset mid-operation.
    step(3'b111, 32'hF000, 1'b0, 1'b0);
    chk("pre_rst.count", 32'(count), 32'd4);
    #2 rst_n = 1'b0;
    #1 chk_state("rst_mid", 5'd0, 3'b000, 1'b0);
    step(3'b000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b000, 32'h0, 1'b0, 1'b0);
    chk_state("after_rst", 5'd0, 3'b000, 1'b0);
    step(3'b111, 32'h1c020000, 1'b0, 1'b0);
    chk_state("after_rst_wr", 5'd3, 3'b111, 1'b0);
    chk("after_rst_wr.pc0", pc_out[0], 32'h1c020000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
